cpu_bus_ctrl: RTL

Parametrised CPU bus interface unit that sits between the control unit's `bus_opcode_t` stream and external memory. It replaces direct combinational bus drive with a registered, wait-state-capable transaction FSM that supports a memory ready handshake, a timeout, and stall back-pressure to `control`. On completion it captures `opcode`, `cb_opcode` or read data. It also keeps cycle and stall performance counters.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/cpu_perf_counter.sv | 20 ++
 rtl/cpu_bus_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU types: bus request opcodes and bus FSM states.
// Imported by the bus controller and its helpers.
package cpu_pkg;

  typedef enum logic [2:0] {
    BUS_NONE  = 3'd0,
    BUS_IF    = 3'd1,
    BUS_READ  = 3'd2,
    BUS_WRITE = 3'd3,
    BUS_IF_CB = 3'd4
  } bus_opcode_t;

  typedef enum logic {
    BUS_IDLE   = 1'b0,
    BUS_ACCESS = 1'b1
  } bus_state_t;

  function automatic logic is_rd_op(bus_opcode_t op);
    return (op == BUS_IF) || (op == BUS_READ) ||
           (op == BUS_IF_CB);
  endfunction

endpackage

// File: rtl/cpu_perf_counter.sv
// Free-running wrap-around event counter.
// Ports: clk, rst (sync, high), en (count enable), count.
module cpu_perf_counter #(
  parameter int CNT_W = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/cpu_bus_ctrl.sv
// CPU bus interface: wait-state/timeout transaction FSM.
// Ports: bus_op/addr_in/wdata_in/wait_cfg request,
// mem_* memory side, stall back-pressure, captured
// opcode/cb_opcode/rdata, sticky bus_err, perf counters.
module cpu_bus_ctrl
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int WAIT_W  = 3,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 48
) (
  input  logic              clk,
  input  logic              rst,
  input  bus_opcode_t       bus_op,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata_in,
  input  logic [WAIT_W-1:0] wait_cfg,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              stall,
  output logic [7:0]        opcode,
  output logic [7:0]        cb_opcode,
  output logic [DATA_W-1:0] rdata,
  output logic              bus_err,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  stall_count
);

  localparam int TO_W = (TIMEOUT > 2) ?
                        $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST =
    TO_W'(TIMEOUT - 1);

  bus_state_t        r_state;
  bus_state_t        w_next;
  bus_opcode_t       r_op;
  logic [WAIT_W-1:0] r_wait_cfg;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [TO_W-1:0]   r_to_cnt;

  logic              w_access;
  logic              w_accept;
  logic              w_done;
  logic              w_tmo;
  logic [DATA_W-1:0] w_cap;

  assign w_access = (r_state == BUS_ACCESS);
  assign w_accept = (r_state == BUS_IDLE) &&
                    (bus_op != BUS_NONE);
  // mem_ready only counts once the wait count is reached
  assign w_done   = w_access &&
                    (r_wait_cnt == r_wait_cfg) &&
                    mem_ready;
  // done on the boundary cycle beats the timeout
  assign w_tmo    = w_access &&
                    (r_to_cnt == TO_LAST) && !w_done;
  // open bus reads back as all-ones on abort
  assign w_cap    = w_done ? mem_rdata : '1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= BUS_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      BUS_IDLE: begin
        if (w_accept) w_next = BUS_ACCESS;
      end
      BUS_ACCESS: begin
        if (w_done || w_tmo) w_next = BUS_IDLE;
      end
      default: w_next = BUS_IDLE;
    endcase
  end

  always_comb begin
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    stall     = 1'b0;
    unique case (r_state)
      BUS_IDLE: begin
        stall = w_accept;
      end
      BUS_ACCESS: begin
        mem_rd_en = is_rd_op(r_op);
        mem_wr_en = (r_op == BUS_WRITE);
        stall     = !w_done && !w_tmo;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op       <= BUS_NONE;
      r_wait_cfg <= '0;
      r_wait_cnt <= '0;
      r_to_cnt   <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      opcode     <= 8'h00;
      cb_opcode  <= 8'h00;
      rdata      <= '0;
      bus_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op       <= bus_op;
        r_wait_cfg <= wait_cfg;
        r_wait_cnt <= '0;
        r_to_cnt   <= '0;
        mem_addr   <= addr_in;
        mem_wdata  <= wdata_in;
      end else if (w_access) begin
        if (r_wait_cnt != r_wait_cfg)
          r_wait_cnt <= r_wait_cnt + 1'b1;
        r_to_cnt <= r_to_cnt + 1'b1;
      end
      if (w_done || w_tmo) begin
        unique case (r_op)
          BUS_IF:    opcode    <= 8'(w_cap);
          BUS_IF_CB: cb_opcode <= 8'(w_cap);
          BUS_READ:  rdata     <= w_cap;
          default:   ;
        endcase
      end
      if (w_tmo) bus_err <= 1'b1;
    end
  end

  cpu_perf_counter #(
    .CNT_W (CNT_W)
  ) u_cyc_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (1'b1),
    .count (cycle_count)
  );

  cpu_perf_counter #(
    .CNT_W (CNT_W)
  ) u_stl_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (stall),
    .count (stall_count)
  );

endmodule
